fp16_mult_arbiter: RTL and testbench
====================================

# fp16_mult_arbiter

Shares one half-precision multiplier (`multhalfprecision`, instantiated internally) among `NUM_REQ` pipeline requesters. Each requester presents two fp16 operands with a valid/ready handshake. A round-robin arbiter grants one request per cycle, and a two-stage registered pipeline returns the product, exception flag and requester tag on a single result port with backpressure. It sits between the shader lanes and the arithmetic datapath, so each lane does not need its own multiplier.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: tag width; must equal ceil(log2(`NUM_REQ`)).
- `i_Clk` input 1: single clock; all state changes on its rising edge.
- `i_Reset_n` input 1: reset, asynchronous and active-low.
- `i_ReqValid` input `NUM_REQ`: bit k is high when requester k has operands pending.
- `i_ReqFactor1` input 16*`NUM_REQ`: requester k's first operand in bits [16k+15:16k].
- `i_ReqFactor2` input 16*`NUM_REQ`: requester k's second operand, same packing.
- `o_ReqReady` output `NUM_REQ`: one-hot or zero; bit k high means requester k's operands are taken this cycle.
- `o_ResValid` output 1: result register holds a valid product.
- `o_ResProduct` output 16: fp16 product.
- `o_ResException` output 1: the multiplier's exception flag for this product.
- `o_ResId` output `ID_W`: index of the requester that issued the product.
- `i_ResReady` input 1: consumer accepts the result this cycle.
- `o_OpCount` output 16: count of results consumed; wraps modulo 2^16.
- `o_Busy` output 1: OR of the stage-1 and stage-2 valid bits.

## Operation
- **Stage 1 (operand register):** holds `s1_valid`, `s1_id`, `s1_a` and `s1_b`. Its contents feed the multiplier combinationally.
- **Stage 2 (result register):** holds `s2_valid`, `s2_id`, product and exception. Its contents drive the `o_Res*` outputs directly.
- **Advance and accept logic:**
  - `s2_free = !s2_valid | i_ResReady`.
  - `s1_adv = s1_valid & s2_free`.
  - `accept = !s1_valid | s1_adv`.
- **Arbitration:**
  - Grant is combinational: the first requester with `i_ReqValid` set, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `o_ReqReady[g] = accept & i_ReqValid[g]` for the granted index g; all other bits are 0.
  - On an accept with a grant, `rr_ptr` becomes (g+1) mod `NUM_REQ`. Otherwise `rr_ptr` holds.
- **Stage 1 update:**
  - On a grant: load the granted operands and tag, and set `s1_valid=1`.
  - Else if `s1_adv`: set `s1_valid=0`.
  - Else: hold.
- **Stage 2 update:**
  - If `s1_adv`: load the multiplier outputs and `s1_id`, and set `s2_valid=1`.
  - Else if `i_ResReady`: set `s2_valid=0`.
  - Else: hold. Stage-2 contents must not change while `o_ResValid=1` and `i_ResReady=0`.
- **Counter:** `o_OpCount` increments by 1 on each cycle where `o_ResValid & i_ResReady`. 0xFFFF wraps to 0x0000.
- **Arithmetic:** there is none in this block. Product and exception are exactly what the multiplier produces for (`s1_a`, `s1_b`).
- **Requester side:** a requester must hold its valid and operands stable until it sees its ready bit. A deasserted valid is never granted.

## Timing
- **Reset (`i_Reset_n`=0, asynchronous):**
  - `s1_valid`, `s2_valid`, `o_ResValid`, `o_Busy` and `o_ReqReady` all go to 0.
  - `o_ResProduct`, `o_ResException`, `o_ResId` and `o_OpCount` go to 0.
  - `rr_ptr` goes to 0, so requester 0 has first priority.
  - Reset in mid-operation drops all in-flight operations without producing output.
  - While reset is asserted, `o_ReqReady` is 0.
- **Latency:** a request accepted at rising edge N has `o_ResValid=1` after edge N+1, with no stall.
- **Throughput:** one operation per cycle while `i_ResReady` stays high.
- **Full pipeline:** stage 2 is stalled and stage 1 is valid. In that state `accept=0` and every `o_ReqReady` is 0.
- **Simultaneous events:**
  - Consume in stage 2, advance from stage 1 and grant a new request can all happen in the same cycle.
  - `o_OpCount` increments in that same cycle.
- **Arbiter when not accepting:** the grant is visible combinationally, but `rr_ptr` moves only when an accept occurs.

## Test plan
- **Single request:** req0 with 0x3C00 × 0x4000 while `i_ResReady`=1. Expect `o_ReqReady`=0001 in the same cycle; two edges later, `o_ResValid`=1, product 0x4000, `o_ResId`=0, exception 0; `o_OpCount`=1 after consumption.
- **Full contention:** all 4 requesters valid and held, first from reset, then continuously. Expect grant order 0,1,2,3,0,... and `o_ResId` sequence 0,1,2,3 on consecutive cycles. req2's product for 0x4200 × 0x4400 is 0x4A00.
- **Backpressure:** `i_ResReady`=0 for 5 cycles with requests pending. Expect the stage-2 outputs stable and `o_ReqReady`=0 after the second accept. When ready is raised, expect back-to-back results with none lost or duplicated.
- **Exception passthrough:** 0x7800 × 0x7800 from req3. Expect `o_ResException`=1 and `o_ResId`=3.
- **Reset mid-flight:** pulse `i_Reset_n` low asynchronously while both stages are valid. Expect all outputs at 0 immediately. After release, expect no stale result and the first grant to go to requester 0.
- **Counter wrap:** preload by running 65536 consumed operations. Expect `o_OpCount` to read 0x0000, then 0x0001 after the next operation.

Source files
------------

// File: rtl/fp16_mult_arbiter.sv
// Round-robin front end sharing one fp16 multiplier among NUM_REQ requesters.
// Two-stage pipeline: operand register, then result register with backpressure.
module multhalfprecision (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p,
    output logic        exc
);
    logic        sgn;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [21:0] m;
    logic [6:0]  ebias;
    logic [9:0]  frac;
    logic        a_nan;
    logic        b_nan;

    // Subnormals flush to zero, mantissa is truncated, overflow saturates to inf.
    always_comb begin
        sgn   = a[15] ^ b[15];
        ea    = a[14:10];
        eb    = b[14:10];
        a_nan = (ea == 5'h1f) && (|a[9:0]);
        b_nan = (eb == 5'h1f) && (|b[9:0]);
        m     = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        ebias = 7'(ea) + 7'(eb) + 7'(m[21]);
        frac  = m[21] ? m[20:11] : m[19:10];
        p     = '0;
        exc   = 1'b0;
        if (ea == 5'h1f || eb == 5'h1f) begin
            exc = 1'b1;
            if (a_nan || b_nan || ea == 5'h00 || eb == 5'h00)
                p = 16'h7e00;
            else
                p = {sgn, 5'h1f, 10'h000};
        end else if (ea == 5'h00 || eb == 5'h00) begin
            p = {sgn, 15'h0000};
        end else if (ebias >= 7'd46) begin
            exc = 1'b1;
            p   = {sgn, 5'h1f, 10'h000};
        end else if (ebias > 7'd15) begin
            p = {sgn, 5'(ebias - 7'd15), frac};
        end else begin
            p = {sgn, 15'h0000};
        end
    end
endmodule

module fp16_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic [NUM_REQ-1:0]     i_ReqValid,
    input  logic [16*NUM_REQ-1:0]  i_ReqFactor1,
    input  logic [16*NUM_REQ-1:0]  i_ReqFactor2,
    output logic [NUM_REQ-1:0]     o_ReqReady,
    output logic                   o_ResValid,
    output logic [15:0]            o_ResProduct,
    output logic                   o_ResException,
    output logic [ID_W-1:0]        o_ResId,
    input  logic                   i_ResReady,
    output logic [15:0]            o_OpCount,
    output logic                   o_Busy
);
    logic [NUM_REQ-1:0][15:0] fa;
    logic [NUM_REQ-1:0][15:0] fb;

    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic            s2_valid;
    logic [ID_W-1:0] s2_id;
    logic [15:0]     s2_p;
    logic            s2_e;
    logic [ID_W-1:0] rr_ptr;
    logic [15:0]     cnt;

    logic            s2_free;
    logic            s1_adv;
    logic            accept;
    logic            grant_hit;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            take;
    logic [15:0]     mul_p;
    logic            mul_e;

    assign fa = i_ReqFactor1;
    assign fb = i_ReqFactor2;

    assign s2_free = !s2_valid | i_ResReady;
    assign s1_adv  = s1_valid & s2_free;
    // Gated by reset so no requester is told it was taken while in reset.
    assign accept  = (!s1_valid | s1_adv) & i_Reset_n;
    assign take    = accept & grant_hit;

    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_hit && i_ReqValid[cand]) begin
                grant_hit = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        o_ReqReady = '0;
        if (take)
            o_ReqReady[grant_id] = 1'b1;
    end

    multhalfprecision u_mul (
        .a   (s1_a),
        .b   (s1_b),
        .p   (mul_p),
        .exc (mul_e)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_p     <= '0;
            s2_e     <= 1'b0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (take) begin
                s1_valid <= 1'b1;
                s1_id    <= grant_id;
                s1_a     <= fa[grant_id];
                s1_b     <= fb[grant_id];
                if (grant_id == ID_W'(NUM_REQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant_id + 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_id    <= s1_id;
                s2_p     <= mul_p;
                s2_e     <= mul_e;
            end else if (i_ResReady) begin
                s2_valid <= 1'b0;
            end
            if (s2_valid && i_ResReady)
                cnt <= cnt + 16'd1;
        end
    end

    assign o_ResValid     = s2_valid;
    assign o_ResProduct   = s2_p;
    assign o_ResException = s2_e;
    assign o_ResId        = s2_id;
    assign o_OpCount      = cnt;
    assign o_Busy         = s1_valid | s2_valid;
endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Scoreboard bench for fp16_mult_arbiter: feeder queues per requester,
// expected results queued on grant, monitor pops on each consumed result.
module tb_fp16_mult_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        e;
    } op_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [15:0]   p;
        logic          e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0][15:0] f1a = '0;
    logic [N-1:0][15:0] f2a = '0;
    logic [16*N-1:0]   f1;
    logic [16*N-1:0]   f2;
    logic [N-1:0]      req_ready;
    logic              res_valid;
    logic [15:0]       res_p;
    logic              res_e;
    logic [IW-1:0]     res_id;
    logic              res_ready = 1'b1;
    logic [15:0]       op_count;
    logic              busy;

    assign f1 = f1a;
    assign f2 = f2a;

    fp16_mult_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .i_Clk          (clk),
        .i_Reset_n      (rst_n),
        .i_ReqValid     (req_valid),
        .i_ReqFactor1   (f1),
        .i_ReqFactor2   (f2),
        .o_ReqReady     (req_ready),
        .o_ResValid     (res_valid),
        .o_ResProduct   (res_p),
        .o_ResException (res_e),
        .o_ResId        (res_id),
        .i_ResReady     (res_ready),
        .o_OpCount      (op_count),
        .o_Busy         (busy)
    );

    op_t    rq [N][$];
    exp_t   sb [$];
    int     glog_id [$];
    int     glog_cyc [$];
    int     glog_val [$];
    int     rlog_id [$];
    int     rlog_cyc [$];
    int     errors = 0;
    int     checks = 0;
    int     n_done = 0;
    int     cyc = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic op_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] p, input logic e);
        op_t o;
        o.a = a;
        o.b = b;
        o.p = p;
        o.e = e;
        return o;
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < 0 || i >= q.size())
            return -1;
        return q[i];
    endfunction

    function automatic bit pending();
        bit r;
        r = 1'b0;
        for (int k = 0; k < N; k++)
            if (rq[k].size() != 0)
                r = 1'b1;
        return r;
    endfunction

    // Requester model: holds valid/operands until its ready bit is seen.
    initial begin : feeder
        logic [N-1:0]  rdy;
        logic [IW-1:0] kk;
        op_t           o;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                kk = IW'(k);
                if (rq[k].size() != 0) begin
                    req_valid[kk] = 1'b1;
                    f1a[kk]       = rq[k][0].a;
                    f2a[kk]       = rq[k][0].b;
                end else begin
                    req_valid[kk] = 1'b0;
                end
            end
            @(negedge clk);
            rdy = req_ready;
            if (rdy != '0) begin
                chk($onehot(rdy) && ((rdy & ~req_valid) == '0), "grant_onehot",
                    32'(rdy), 32'(req_valid));
                for (int k = 0; k < N; k++) begin
                    kk = IW'(k);
                    if (rdy[kk] && rq[k].size() != 0) begin
                        o = rq[k].pop_front();
                        sb.push_back('{id: kk, p: o.p, e: o.e});
                        glog_id.push_back(k);
                        glog_cyc.push_back(cyc);
                        glog_val.push_back(int'(rdy));
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                n_done = 0;
            end else if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_result", 32'(res_p), 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    chk(res_p == e.p, "product", 32'(res_p), 32'(e.p));
                    chk(res_id == e.id, "res_id", 32'(res_id), 32'(e.id));
                    chk(res_e == e.e, "exception", 32'(res_e), 32'(e.e));
                end
                chk(op_count == n_done[15:0], "op_count_run",
                    32'(op_count), 32'(n_done[15:0]));
                n_done++;
                rlog_id.push_back(int'(res_id));
                rlog_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_drain(input int lim);
        int t;
        t = 0;
        while (t < lim && (pending() || sb.size() != 0 || busy)) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= lim)
            chk(1'b0, "drain_timeout", 32'(t), 32'(lim));
    endtask

    task automatic check_zero(input string tag);
        chk(res_valid == 1'b0, {tag, "_valid"}, 32'(res_valid), 0);
        chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 0);
        chk(req_ready == '0, {tag, "_ready"}, 32'(req_ready), 0);
        chk(res_p == 16'h0, {tag, "_product"}, 32'(res_p), 0);
        chk(res_id == '0, {tag, "_id"}, 32'(res_id), 0);
        chk(res_e == 1'b0, {tag, "_exc"}, 32'(res_e), 0);
        chk(op_count == 16'h0, {tag, "_count"}, 32'(op_count), 0);
    endtask

    op_t tbl [8];
    int  gb;
    int  rb;

    initial begin
        tbl[0] = mk(16'h3c00, 16'h4000, 16'h4000, 1'b0);
        tbl[1] = mk(16'h4000, 16'h4000, 16'h4400, 1'b0);
        tbl[2] = mk(16'h4200, 16'h4400, 16'h4a00, 1'b0);
        tbl[3] = mk(16'h3800, 16'h3800, 16'h3400, 1'b0);
        tbl[4] = mk(16'hbc00, 16'h4000, 16'hc000, 1'b0);
        tbl[5] = mk(16'h0000, 16'h4000, 16'h0000, 1'b0);
        tbl[6] = mk(16'h3e00, 16'h3e00, 16'h4080, 1'b0);
        tbl[7] = mk(16'h7bff, 16'h3c00, 16'h7bff, 1'b0);

        // Requests pending while still in reset: nothing may be taken.
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++)
                rq[k].push_back(tbl[4*r + k]);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain(200);

        // Full contention from reset: 0,1,2,3,0,... back to back.
        for (int i = 0; i < 8; i++) begin
            chk(at(glog_id, i) == i % 4, "grant_order", 32'(at(glog_id, i)), 32'(i % 4));
            chk(at(rlog_id, i) == i % 4, "result_order", 32'(at(rlog_id, i)), 32'(i % 4));
            if (i > 0)
                chk(at(rlog_cyc, i) - at(rlog_cyc, i - 1) == 1, "throughput",
                    32'(at(rlog_cyc, i) - at(rlog_cyc, i - 1)), 1);
        end
        chk(at(glog_val, 0) == 1, "first_ready", 32'(at(glog_val, 0)), 1);

        // Single request: ready 0001, result two edges later.
        gb = glog_id.size();
        rb = rlog_id.size();
        @(posedge clk);
        #1;
        rq[0].push_back(tbl[0]);
        wait_drain(50);
        chk(at(glog_val, gb) == 1, "single_ready", 32'(at(glog_val, gb)), 1);
        chk(at(rlog_cyc, rb) - at(glog_cyc, gb) == 2, "latency",
            32'(at(rlog_cyc, rb) - at(glog_cyc, gb)), 2);
        chk(op_count == 16'd9, "count_single", 32'(op_count), 9);

        // Overflow raises the exception flag.
        rb = rlog_id.size();
        @(posedge clk);
        #1;
        rq[3].push_back(mk(16'h7800, 16'h7800, 16'h7c00, 1'b1));
        wait_drain(50);
        chk(at(rlog_id, rb) == 3, "exc_id", 32'(at(rlog_id, rb)), 3);

        // Backpressure: two accepts fill the pipe, then everything stalls.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int k = 0; k < N; k++)
            rq[k].push_back(tbl[k]);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk(req_ready == '0, "stall_ready", 32'(req_ready), 0);
            chk(res_valid == 1'b1, "stall_valid", 32'(res_valid), 1);
            chk(sb.size() == 2, "stall_inflight", 32'(sb.size()), 2);
            if (sb.size() != 0) begin
                chk(res_p == sb[0].p, "stall_product", 32'(res_p), 32'(sb[0].p));
                chk(res_id == sb[0].id, "stall_id", 32'(res_id), 32'(sb[0].id));
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain(50);
        chk(op_count == 16'd14, "count_after_stall", 32'(op_count), 14);

        // Reset while both stages hold operations.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int k = 0; k < N; k++)
            rq[k].push_back(tbl[4 + k]);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        for (int k = 0; k < N; k++)
            rq[k].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        gb = glog_id.size();
        for (int k = N - 1; k >= 0; k--)
            rq[k].push_back(tbl[k]);
        @(negedge clk);
        chk(res_valid == 1'b0, "no_stale", 32'(res_valid), 0);
        wait_drain(50);
        chk(at(glog_id, gb) == 0, "first_after_reset", 32'(at(glog_id, gb)), 0);
        chk(op_count == 16'd4, "count_after_reset", 32'(op_count), 4);

        // Counter wrap after 65536 consumed results from zero.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++)
            rq[i % N].push_back(mk(16'h3c00, 16'h3c00, 16'h3c00, 1'b0));
        wait_drain(70000);
        chk(op_count == 16'h0000, "count_wrap", 32'(op_count), 0);
        @(posedge clk);
        #1;
        rq[2].push_back(tbl[2]);
        wait_drain(50);
        chk(op_count == 16'h0001, "count_after_wrap", 32'(op_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
